etapa0_entrada: RTL and testbench

ETAPA0_ENTRADA -- requirements
Module: etapa0_entrada

---
 rtl/etapa0_entrada_pkg.sv | 28 ++
 rtl/etapa0_entrada_if.sv | 40 ++++
 rtl/fifo_op2.sv | 69 ++++++
 rtl/etapa0_entrada.sv | 106 ++++++++++
 tb/tb_etapa0_entrada.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/etapa0_entrada_pkg.sv
// Shared divider definitions for the etapa pipeline blocks.
// Holds the default operand/quotient MSB indices, the default result-slot
// credit count, the credit counter width and the credit update helper.
package etapa0_entrada_pkg;

   localparam int unsigned DvLen       = 15;
   localparam int unsigned DdLen       = 31;
   localparam int unsigned QLen        = 15;
   localparam int unsigned CreditosDef = 4;
   localparam int unsigned CntW        = 3;

   // Next credit value: issue spends one, a return adds one, both cancel.
   // A return at the ceiling is dropped here; the caller flags the overflow.
   function automatic logic [CntW-1:0] credit_next(input logic [CntW-1:0] cnt,
                                                   input logic            issue,
                                                   input logic            ret,
                                                   input logic [CntW-1:0] lim);
      logic [CntW-1:0] nxt;
      nxt = cnt;
      if (issue && !ret) begin
         nxt = cnt - CntW'(1);
      end else if (ret && !issue && (cnt != lim)) begin
         nxt = cnt + CntW'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/etapa0_entrada_if.sv
// Operand/issue bus of the divider entry stage.
// master: producer + downstream stage (drives validIn, operands, creditRet).
// slave : etapa0_entrada (drives readyOut, goOut, issued data and flags,
//         creditCount, errCredito).
interface etapa0_entrada_if
   import etapa0_entrada_pkg::*;
#(
   parameter int unsigned AnchoDv = DvLen,
   parameter int unsigned AnchoDd = DdLen,
   parameter int unsigned AnchoQ  = QLen
);
   logic              validIn;
   logic [AnchoDv:0]  divisorIn;
   logic [AnchoDd:0]  dividendIn;
   logic              readyOut;
   logic              creditRet;
   logic              goOut;
   logic [AnchoDv:0]  divisorOut;
   logic [AnchoDd:0]  dividendOut;
   logic [AnchoQ:0]   quotientOut;
   logic              negDivisorOut;
   logic              negDividendOut;
   logic              DivisorNoCeroOut;
   logic [CntW-1:0]   creditCount;
   logic              errCredito;

   modport master (
      output validIn, divisorIn, dividendIn, creditRet,
      input  readyOut, goOut, divisorOut, dividendOut, quotientOut,
             negDivisorOut, negDividendOut, DivisorNoCeroOut,
             creditCount, errCredito
   );

   modport slave (
      input  validIn, divisorIn, dividendIn, creditRet,
      output readyOut, goOut, divisorOut, dividendOut, quotientOut,
             negDivisorOut, negDividendOut, DivisorNoCeroOut,
             creditCount, errCredito
   );
endinterface

// File: rtl/fifo_op2.sv
// Two-entry operand FIFO, head always in slot 0.
// Ports: clk, rst_n (async active-low), i_push/i_din write side,
// i_pop read side, o_dout head data, o_nonempty, o_ready (registered,
// 1 when fewer than two entries; 0 while in reset).
module fifo_op2 #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_dout,
   output logic         o_nonempty,
   output logic         o_ready
);

   logic [1:0]   r_count;
   logic [W-1:0] r_slot0;
   logic [W-1:0] r_slot1;
   logic         r_ready;

   logic         w_push;
   logic         w_pop;
   logic [1:0]   w_count_nxt;
   logic [1:0]   w_wr_pos;

   assign w_push = i_push && r_ready;
   assign w_pop  = i_pop && (r_count != 2'd0);

   // Occupancy update and write slot (a same-edge pop frees the head first).
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 2'd1;
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - 2'd1;
      end
      w_wr_pos = r_count - {1'b0, w_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 2'd0;
         r_slot0 <= '0;
         r_slot1 <= '0;
         r_ready <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt < 2'd2);
         if (w_pop) begin
            r_slot0 <= r_slot1;
         end
         // Later assignment wins over the shift when the write lands in slot 0.
         if (w_push) begin
            if (w_wr_pos == 2'd0) begin
               r_slot0 <= i_din;
            end else begin
               r_slot1 <= i_din;
            end
         end
      end
   end

   assign o_dout     = r_slot0;
   assign o_nonempty = (r_count != 2'd0);
   assign o_ready    = r_ready;

endmodule

// File: rtl/etapa0_entrada.sv
// Divider entry stage: queues signed operand pairs, and while result-slot
// credits remain issues one pair per cycle as magnitudes plus sign/zero
// flags with a one-cycle goOut strobe.
// Ports: clk, reset (async active-low), bus (etapa0_entrada_if.slave) with
// the producer handshake, the issued operation and the credit state.
module etapa0_entrada
   import etapa0_entrada_pkg::*;
#(
   parameter int unsigned AnchoDv  = DvLen,
   parameter int unsigned AnchoDd  = DdLen,
   parameter int unsigned AnchoQ   = QLen,
   parameter int unsigned Creditos = CreditosDef
) (
   input  logic             clk,
   input  logic             reset,
   etapa0_entrada_if.slave  bus
);

   localparam int unsigned DvW   = AnchoDv + 1;
   localparam int unsigned DdW   = AnchoDd + 1;
   localparam int unsigned QW    = AnchoQ + 1;
   localparam int unsigned PairW = DvW + DdW;
   localparam logic [CntW-1:0] CredMax = CntW'(Creditos);

   logic             w_ready;
   logic             w_nonempty;
   logic             w_push;
   logic             w_issue;
   logic [PairW-1:0] w_head;
   logic [DvW-1:0]   w_head_dv;
   logic [DdW-1:0]   w_head_dd;
   logic [DvW-1:0]   w_dv_mag;
   logic [DdW-1:0]   w_dd_mag;

   logic             r_go;
   logic [DvW-1:0]   r_dv;
   logic [DdW-1:0]   r_dd;
   logic [QW-1:0]    r_q;
   logic             r_neg_dv;
   logic             r_neg_dd;
   logic             r_nz;
   logic [CntW-1:0]  r_credit;
   logic             r_err;

   assign w_push  = bus.validIn && w_ready;
   assign w_issue = w_nonempty && (r_credit != '0);

   fifo_op2 #(.W(PairW)) u_fifo (
      .clk        (clk),
      .rst_n      (reset),
      .i_push     (w_push),
      .i_din      ({bus.divisorIn, bus.dividendIn}),
      .i_pop      (w_issue),
      .o_dout     (w_head),
      .o_nonempty (w_nonempty),
      .o_ready    (w_ready)
   );

   assign w_head_dv = w_head[PairW-1 -: DvW];
   assign w_head_dd = w_head[DdW-1:0];

   // Two's-complement magnitude; the most-negative value wraps to itself.
   assign w_dv_mag = w_head_dv[DvW-1] ? DvW'(-w_head_dv) : w_head_dv;
   assign w_dd_mag = w_head_dd[DdW-1] ? DdW'(-w_head_dd) : w_head_dd;

   // Issue registers hold between issues; credit counter and sticky overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_go     <= 1'b0;
         r_dv     <= '0;
         r_dd     <= '0;
         r_q      <= '0;
         r_neg_dv <= 1'b0;
         r_neg_dd <= 1'b0;
         r_nz     <= 1'b0;
         r_credit <= CredMax;
         r_err    <= 1'b0;
      end else begin
         r_go <= w_issue;
         if (w_issue) begin
            r_dv     <= w_dv_mag;
            r_dd     <= w_dd_mag;
            r_q      <= '0;
            r_neg_dv <= w_head_dv[DvW-1];
            r_neg_dd <= w_head_dd[DdW-1];
            r_nz     <= (w_head_dv != '0);
         end
         r_credit <= credit_next(r_credit, w_issue, bus.creditRet, CredMax);
         if (bus.creditRet && !w_issue && (r_credit == CredMax)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.readyOut         = w_ready;
   assign bus.goOut            = r_go;
   assign bus.divisorOut       = r_dv;
   assign bus.dividendOut      = r_dd;
   assign bus.quotientOut      = r_q;
   assign bus.negDivisorOut    = r_neg_dv;
   assign bus.negDividendOut   = r_neg_dd;
   assign bus.DivisorNoCeroOut = r_nz;
   assign bus.creditCount      = r_credit;
   assign bus.errCredito       = r_err;

endmodule

// File: tb/tb_etapa0_entrada.sv
// Self-checking bench for etapa0_entrada: directed scenarios plus a random
// phase, all compared every cycle against a queue/integer reference model.
module tb_etapa0_entrada;

   localparam int CRED = 4;

   logic clk;
   logic rst_n;

   etapa0_entrada_if #(.AnchoDv(15), .AnchoDd(31), .AnchoQ(15)) bus ();

   etapa0_entrada #(
      .AnchoDv (15),
      .AnchoDd (31),
      .AnchoQ  (15),
      .Creditos(CRED)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [15:0] dv;
      logic [31:0] dd;
   } pair_t;

   pair_t       q[$];
   int          tests;
   int          fails;
   int          m_cred;
   bit          m_err;
   bit          m_ready;
   bit          m_go;
   logic [15:0] e_dv;
   logic [31:0] e_dd;
   logic        e_ndv;
   logic        e_ndd;
   logic        e_nz;
   int          go_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("goOut",            32'(bus.goOut),            32'(m_go));
      chk("readyOut",         32'(bus.readyOut),         32'(m_ready));
      chk("creditCount",      32'(bus.creditCount),      32'(m_cred));
      chk("errCredito",       32'(bus.errCredito),       32'(m_err));
      chk("divisorOut",       32'(bus.divisorOut),       32'(e_dv));
      chk("dividendOut",      bus.dividendOut,           e_dd);
      chk("quotientOut",      32'(bus.quotientOut),      32'h0);
      chk("negDivisorOut",    32'(bus.negDivisorOut),    32'(e_ndv));
      chk("negDividendOut",   32'(bus.negDividendOut),   32'(e_ndd));
      chk("DivisorNoCeroOut", 32'(bus.DivisorNoCeroOut), 32'(e_nz));
   endtask

   task automatic m_reset();
      q.delete();
      m_cred  = CRED;
      m_err   = 1'b0;
      m_ready = 1'b0;
      m_go    = 1'b0;
      e_dv    = '0;
      e_dd    = '0;
      e_ndv   = 1'b0;
      e_ndd   = 1'b0;
      e_nz    = 1'b0;
   endtask

   function automatic logic [15:0] rdv();
      case ($urandom % 8)
         0:       return 16'h0000;
         1:       return 16'h8000;
         2:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] rdd();
      case ($urandom % 8)
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   // One clock: drive inputs, advance the model across the edge, compare.
   task automatic cycle(input bit v, input logic [15:0] dv, input logic [31:0] dd, input bit ret);
      pair_t  p;
      pair_t  np;
      bit     issue;
      bit     accept;
      longint s;
      bus.validIn    = v;
      bus.divisorIn  = dv;
      bus.dividendIn = dd;
      bus.creditRet  = ret;
      @(posedge clk);
      issue  = (q.size() > 0) && (m_cred > 0);
      accept = v && m_ready;
      m_go   = issue;
      if (issue) begin
         p     = q.pop_front();
         s     = longint'($signed(p.dv));
         e_ndv = (s < 0);
         if (s < 0) s = -s;
         e_dv  = 16'(s);
         s     = longint'($signed(p.dd));
         e_ndd = (s < 0);
         if (s < 0) s = -s;
         e_dd  = 32'(s);
         e_nz  = (p.dv != 16'h0);
      end
      if (accept) begin
         np.dv = dv;
         np.dd = dd;
         q.push_back(np);
      end
      if (issue && !ret) begin
         m_cred--;
      end else if (ret && !issue) begin
         if (m_cred == CRED) m_err = 1'b1;
         else m_cred++;
      end
      m_ready = (q.size() < 2);
      #1;
      check_all();
      if (bus.goOut) go_seen++;
   endtask

   // Assert reset mid-cycle, hold two edges, release away from the edge.
   task automatic apply_reset();
      bus.validIn   = 1'b0;
      bus.creditRet = 1'b0;
      rst_n = 1'b0;
      #1;
      m_reset();
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0, 32'h0, m_cred < CRED);
      chk("drain_credits", 32'(bus.creditCount), 32'(CRED));
      chk("drain_ready",   32'(bus.readyOut),    32'h1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      go_seen = 0;
      rst_n = 1'b1;
      bus.validIn    = 1'b0;
      bus.divisorIn  = '0;
      bus.dividendIn = '0;
      bus.creditRet  = 1'b0;
      m_reset();
      #2;
      apply_reset();
      chk("rst_ready_low", 32'(bus.readyOut), 32'h0);
      cycle(1'b0, 16'h0, 32'h0, 1'b0);
      chk("rst_ready_rise", 32'(bus.readyOut), 32'h1);

      // (-7, 100)
      cycle(1'b1, 16'hFFF9, 32'h0000_0064, 1'b0);
      chk("p36_go_early", 32'(bus.goOut), 32'h0);
      cycle(1'b0, 16'h0, 32'h0, 1'b0);
      chk("p36_go",    32'(bus.goOut),            32'h1);
      chk("p36_dv",    32'(bus.divisorOut),       32'h7);
      chk("p36_dd",    bus.dividendOut,           32'h64);
      chk("p36_ndv",   32'(bus.negDivisorOut),    32'h1);
      chk("p36_ndd",   32'(bus.negDividendOut),   32'h0);
      chk("p36_nz",    32'(bus.DivisorNoCeroOut), 32'h1);
      chk("p36_q",     32'(bus.quotientOut),      32'h0);
      cycle(1'b0, 16'h0, 32'h0, 1'b1);
      chk("p36_hold_dv", 32'(bus.divisorOut), 32'h7);

      // zero divisor, most-negative dividend
      cycle(1'b1, 16'h0000, 32'h8000_0000, 1'b0);
      cycle(1'b0, 16'h0, 32'h0, 1'b0);
      chk("p37_go",   32'(bus.goOut),            32'h1);
      chk("p37_nz",   32'(bus.DivisorNoCeroOut), 32'h0);
      chk("p37_dd",   bus.dividendOut,           32'h8000_0000);
      chk("p37_ndd",  32'(bus.negDividendOut),   32'h1);
      chk("p37_cred", 32'(bus.creditCount),      32'(CRED - 1));
      cycle(1'b0, 16'h0, 32'h0, 1'b1);

      // credit exhaustion with back-to-back pairs
      go_seen = 0;
      for (int i = 0; i < 10; i++) cycle(1'b1, rdv(), rdd(), 1'b0);
      chk("p38_gocount", 32'(go_seen),          32'h4);
      chk("p38_cred0",   32'(bus.creditCount),  32'h0);
      chk("p38_ready0",  32'(bus.readyOut),     32'h0);
      cycle(1'b0, 16'h0, 32'h0, 1'b1);
      chk("p38_ret_nogo", 32'(bus.goOut), 32'h0);
      cycle(1'b0, 16'h0, 32'h0, 1'b0);
      chk("p38_one_more", 32'(bus.goOut), 32'h1);
      cycle(1'b0, 16'h0, 32'h0, 1'b0);
      chk("p38_no_third", 32'(bus.goOut), 32'h0);
      drain();

      // same-edge issue and return, then overflow at the ceiling
      cycle(1'b1, rdv(), rdd(), 1'b0);
      cycle(1'b1, rdv(), rdd(), 1'b0);
      cycle(1'b0, 16'h0, 32'h0, 1'b0);
      chk("p39_cred2", 32'(bus.creditCount), 32'h2);
      cycle(1'b1, rdv(), rdd(), 1'b0);
      cycle(1'b0, 16'h0, 32'h0, 1'b1);
      chk("p39_go_ret", 32'(bus.goOut),       32'h1);
      chk("p39_stay2",  32'(bus.creditCount), 32'h2);
      drain();
      chk("p39_err_clear", 32'(bus.errCredito), 32'h0);
      cycle(1'b0, 16'h0, 32'h0, 1'b1);
      chk("p39_err",    32'(bus.errCredito),  32'h1);
      chk("p39_stay4",  32'(bus.creditCount), 32'(CRED));
      cycle(1'b0, 16'h0, 32'h0, 1'b0);
      chk("p39_sticky", 32'(bus.errCredito),  32'h1);

      // random traffic
      for (int i = 0; i < 300; i++)
         cycle(($urandom % 10) < 7, rdv(), rdd(), ($urandom % 3) == 0);
      drain();

      // reset with two queued pairs and one credit
      for (int i = 0; i < 20 && !(q.size() == 2 && m_cred == 0); i++)
         cycle(1'b1, rdv(), rdd(), 1'b0);
      cycle(1'b0, 16'h0, 32'h0, 1'b1);
      chk("p40_cred1",  32'(bus.creditCount), 32'h1);
      chk("p40_full",   32'(bus.readyOut),    32'h0);
      apply_reset();
      chk("p40_rst_cred", 32'(bus.creditCount), 32'(CRED));
      chk("p40_rst_dv",   32'(bus.divisorOut),  32'h0);
      chk("p40_rst_err",  32'(bus.errCredito),  32'h0);
      cycle(1'b0, 16'h0, 32'h0, 1'b0);
      chk("p40_no_go",  32'(bus.goOut),    32'h0);
      chk("p40_ready",  32'(bus.readyOut), 32'h1);
      cycle(1'b0, 16'h0, 32'h0, 1'b0);
      chk("p40_no_go2", 32'(bus.goOut),    32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
